// File: rtl/xmit_pkg.sv
// Shared constants and types for the serial frame transmitter.
// MATCH is the frame header the receiver synchronises on.
package xmit_pkg;

    localparam logic [7:0] MATCH     = 8'hA5;
    localparam int         FRAME_LEN = 16;
    localparam logic [3:0] CNT_LAST  = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } xmit_state_e;

    // Build the 16-bit on-wire frame: header followed by body, MSB first.
    function automatic logic [15:0] frame_word(input logic [7:0] body);
        return {MATCH, body};
    endfunction

endpackage

// File: rtl/xmit.sv
// Serial frame transmitter: 8'hA5 header + one body byte, MSB first, with an
// optional inter-frame gap. Define XMIT_OVERRUN_EN to add the overrun flag.
module xmit
    import xmit_pkg::*;
#(
    parameter int IDLE_BITS = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       data_out,
    output logic       full,
    output logic       busy,
    output logic       sent
`ifdef XMIT_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    localparam logic [3:0] GAP_LAST = 4'(IDLE_BITS - 1);
    localparam logic       NO_GAP   = (IDLE_BITS == 32'sd0);

    xmit_state_e state_r;
    logic [15:0] shift_r;
    logic [3:0]  cnt_r;
    logic [3:0]  gap_cnt_r;
    logic [7:0]  hold_r;
    logic        full_r;
    logic        busy_r;
    logic        sent_r;

    logic        accept_s;
    logic        frame_end_s;
    logic        gap_end_s;
    logic        start_s;

    assign accept_s    = load & ~full_r;
    assign frame_end_s = (state_r == ST_SEND) && (cnt_r == CNT_LAST);
    assign gap_end_s   = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);
    // A queued byte is consumed when idle, at frame end without a gap, or at gap end.
    assign start_s     = full_r && ((state_r == ST_IDLE) ||
                                    (frame_end_s && NO_GAP) ||
                                    gap_end_s);

    assign data_out = shift_r[15];
    assign full     = full_r;
    assign busy     = busy_r;
    assign sent     = sent_r;

    // Holding register and its occupancy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_r <= 8'h00;
            full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r <= data_in;
            full_r <= 1'b1;
        end else if (start_s) begin
            full_r <= 1'b0;
        end
    end

    // Frame sequencer: shift register, bit counter, gap counter and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 16'h0000;
            cnt_r     <= 4'd0;
            gap_cnt_r <= 4'd0;
            busy_r    <= 1'b0;
            sent_r    <= 1'b0;
        end else begin
            sent_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (full_r) begin
                        state_r <= ST_SEND;
                        shift_r <= frame_word(hold_r);
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (cnt_r == CNT_LAST) begin
                        sent_r <= 1'b1;
                        cnt_r  <= 4'd0;
                        if (NO_GAP && full_r) begin
                            shift_r <= frame_word(hold_r);
                        end else if (NO_GAP) begin
                            state_r <= ST_IDLE;
                            shift_r <= {shift_r[14:0], 1'b0};
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_GAP;
                            shift_r   <= {shift_r[14:0], 1'b0};
                            gap_cnt_r <= 4'd0;
                        end
                    end else begin
                        shift_r <= {shift_r[14:0], 1'b0};
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                ST_GAP: begin
                    // A byte already waiting starts straight from the last gap
                    // cycle so the line carries exactly IDLE_BITS zeros.
                    if (gap_cnt_r == GAP_LAST) begin
                        if (full_r) begin
                            state_r <= ST_SEND;
                            shift_r <= frame_word(hold_r);
                            cnt_r   <= 4'd0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    shift_r   <= 16'h0000;
                    cnt_r     <= 4'd0;
                    gap_cnt_r <= 4'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef XMIT_OVERRUN_EN
    logic reject_s;
    logic overrun_r;

    assign reject_s = load & full_r;
    assign overrun  = overrun_r;

    // Sticky flag for a load dropped because the holding register was occupied.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (reject_s) begin
            overrun_r <= 1'b1;
        end else if (accept_s) begin
            overrun_r <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/xmit.md
XMIT -- requirements
Module: xmit

Interface
REQ-001 Parameter IDLE_BITS, default 0: minimum number of 0 bits driven between consecutive frames (0..15).
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) clears state immediately, release is synchronous to clock.
REQ-004 load  input  1  write strobe for data_in; sampled on rising edge.
REQ-005 data_in  input  8  frame body byte, captured when a load is accepted.
REQ-006 data_out  output  1  registered serial line: frame bits MSB first, 0 when idle.
REQ-007 full  output  1  holding register occupied.
REQ-008 busy  output  1  frame or inter-frame gap in progress (state != IDLE).
REQ-009 sent  output  1  one-cycle pulse after the last body bit has been driven.

Function
REQ-010 Frame SHALL be 16 bits: header MATCH = 8'hA5, then body byte, both MSB first, one bit per clock.
REQ-011 Load SHALL be accepted iff load=1 and full=0 at the edge; accepted byte goes to holding register, full<=1.
REQ-012 Load with full=1 SHALL be ignored; holding register unchanged.
REQ-013 FSM states: IDLE, SEND, GAP.
REQ-014 IDLE: on edge with full=1 -> SEND; 16-bit shift register <= {MATCH, hold}; bit counter <= 0; full<=0.
REQ-015 A load on that same edge SHALL be rejected, because full was 1 when sampled.
REQ-016 data_out SHALL equal shift register bit 15; the register shifts left with zero fill each SEND cycle.
REQ-017 First header bit (1) SHALL appear on data_out one cycle after the IDLE->SEND edge.
REQ-018 Latency: load accepted at edge N with FSM idle -> header MSB on data_out after edge N+1.
REQ-019 SEND: counter increments each edge. At count 15, sent<=1 for one cycle.
REQ-020 At count 15 with IDLE_BITS=0 and full=1: reload directly (back-to-back, no gap).
REQ-021 At count 15 with IDLE_BITS=0 and full=0: -> IDLE.
REQ-022 At count 15 with IDLE_BITS>0: -> GAP.
REQ-023 GAP SHALL drive data_out=0 for exactly IDLE_BITS cycles, then -> IDLE.
REQ-024 A byte loaded during SEND or GAP SHALL wait in the holding register and start per REQ-014/020.
REQ-025 busy=1 in SEND and GAP; full and busy are independent.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, data_out=0, full=0, busy=0, sent=0, counter=0, shift register=0.
REQ-027 Reset mid-frame SHALL abort the frame without completion; the holding byte is discarded.
REQ-028 The first frame after reset release SHALL start only after a fresh accepted load.

Configuration
REQ-029 Macro XMIT_OVERRUN_EN defined: output overrun (1 bit) exists.
REQ-030 overrun is set on a load rejected per REQ-012, cleared on the next accepted load, and reset to 0.
REQ-031 XMIT_OVERRUN_EN undefined: no overrun port or logic; rejected loads are silent.

Structure
REQ-032 Package xmit_pkg SHALL hold MATCH (8'hA5, shared with the receiver), the frame length constant 16, and the FSM state typedef.
REQ-033 A single module; no sub-module. The shift register, counter, and holding register are inline.

Verification
REQ-034 Reset released, load 8'h3C once -> data_out stream 1010_0101_0011_1100 starting after edge 2; sent pulses once; busy low after.
REQ-035 IDLE_BITS=0, loads 8'h00 then 8'hFF (second during first frame) -> 32 contiguous bits A5 00 A5 FF, no gap.
REQ-036 IDLE_BITS=3, two queued bytes 8'h81, 8'h7E -> exactly three 0 bits between frames.
REQ-037 Load 8'h11, then loads 8'h22 and 8'h33 while full -> 8'h33 dropped; with XMIT_OVERRUN_EN, overrun=1 until next accepted load.
REQ-038 Assert reset at bit 5 of a frame -> data_out=0 and full=0 immediately; no sent pulse; line stays 0 until a new load.
REQ-039 Connect data_out to the receiver's data_in and send 8'hA5, 8'h5A -> receiver data_out matches each byte and ready asserts per frame.
